// File: rtl/line_arbiter_n.sv
// N-requester line arbiter. It sits between the L1 cache ports and the single
// cacheline-adapter/L2 port, with one line transaction outstanding at a time.
//
// Handshake: each requester holds port_read/port_write, with its address and
// data, as a level until it sees its one-cycle port_resp pulse. It must drop the
// request on the cycle after the pulse. Downstream, down_read/down_write stay
// high with down_addr/down_wdata stable until down_resp pulses. They are then
// low for at least one cycle before the next grant.
module line_arbiter_n #(
  parameter  int NUM_PORTS  = 2,
  parameter  int LINE_WIDTH = 256,
  parameter  int ADDR_WIDTH = 32,
  parameter  int RR_MODE    = 1,
  localparam int IDW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  port_wdata,
  output logic [LINE_WIDTH-1:0]            port_rdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic                             down_read,
  output logic                             down_write,
  output logic [ADDR_WIDTH-1:0]            down_addr,
  output logic [LINE_WIDTH-1:0]            down_wdata,
  input  logic [LINE_WIDTH-1:0]            down_rdata,
  input  logic                             down_resp,
  output logic                             busy,
  output logic [IDW-1:0]                   grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [NUM_PORTS-1:0] req;
  logic [IDW-1:0]       winner;
  logic                 found;
  logic                 grant_now;
  logic                 done;

  assign req        = port_read | port_write;
  assign busy       = (state_q == BUSY);
  assign port_rdata = down_rdata;

  // Winner selection: lowest index in fixed mode, or the first requester found
  // scanning upward from the port after the last winner in round-robin mode.
  always_comb begin
    logic [IDW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) idx = IDW'((int'(rr_ptr_q) + 1 + k) % NUM_PORTS);
      else              idx = IDW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next state. There is no regrant on the response cycle, because the
  // return to IDLE always costs one cycle.
  always_comb begin
    state_d   = state_q;
    grant_now = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          grant_now = 1'b1;
        end
      end
      BUSY: begin
        if (down_resp) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse goes only to the granted port, on the down_resp cycle.
  always_comb begin
    port_resp = '0;
    if (done) port_resp[grant_id] = 1'b1;
  end

  // State register plus the captured transaction. A write wins over a read on
  // a port that illegally asserts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      down_read  <= 1'b0;
      down_write <= 1'b0;
      down_addr  <= '0;
      down_wdata <= '0;
      grant_id   <= '0;
      rr_ptr_q   <= IDW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        down_write <= port_write[winner];
        down_read  <= port_read[winner] & ~port_write[winner];
        down_addr  <= port_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        down_wdata <= port_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
        grant_id   <= winner;
        if (RR_MODE != 0) rr_ptr_q <= winner;
      end
      if (done) begin
        down_read  <= 1'b0;
        down_write <= 1'b0;
      end
    end
  end

endmodule
